dsss_rx_descrambler_sync: RTL and testbench

//   Receive-side counterpart of the TX scrambler: self-synchronising 802.11b descrambler, G(z)=1+z^-4+z^-7.

---
 rtl/dsss_rx_pkg.sv | 30 +++
 rtl/dsss_descrambler_core.sv | 32 +++
 rtl/dsss_rx_descrambler_sync.sv | 170 +++++++++++++++++
 tb/tb_dsss_rx_descrambler_sync.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsss_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : dsss_rx_pkg
//  Purpose   : Shared types and constants for the 802.11b DSSS RX descrambler
//              and preamble synchroniser.
//  Revision  : 1.0  initial release
// ============================================================================
package dsss_rx_pkg;

  typedef enum logic [1:0] {
    HUNT       = 2'd0,
    SFD_SEARCH = 2'd1,
    DATA       = 2'd2
  } rx_state_t;

  localparam logic [15:0] SFD_LONG  = 16'hF3A0;
  localparam logic [15:0] SFD_SHORT = 16'h05CF;

  localparam int TAP_A    = 3;
  localparam int TAP_B    = 6;
  localparam int LFSR_LEN = 7;

  // G(z)=1+z^-4+z^-7 applied to the raw received bit and its history.
  function automatic logic descramble_bit(input logic b,
                                          input logic [LFSR_LEN-1:0] sr);
    return b ^ sr[TAP_A] ^ sr[TAP_B];
  endfunction

endpackage
`default_nettype wire

// File: rtl/dsss_descrambler_core.sv
`default_nettype none
// ============================================================================
//  Module    : dsss_descrambler_core
//  Purpose   : Self-synchronising descrambler datapath: 7-bit history of raw
//              received bits plus XOR taps producing the descrambled bit.
//  Revision  : 1.0  initial release
// ============================================================================
module dsss_descrambler_core
  import dsss_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic bit_in,
  output logic d
);

  logic [LFSR_LEN-1:0] r_sr;

  // The history holds the scrambled bit, which is what makes it self-syncing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= '0;
    end else if (en) begin
      r_sr <= {r_sr[LFSR_LEN-2:0], bit_in};
    end
  end

  assign d = descramble_bit(bit_in, r_sr);

endmodule
`default_nettype wire

// File: rtl/dsss_rx_descrambler_sync.sv
`default_nettype none
// ============================================================================
//  Module    : dsss_rx_descrambler_sync
//  Purpose   : 802.11b RX descrambler with SYNC-ones lock, SFD search and
//              post-SFD bit output. Optional raw bypass via DESCR_BYPASS_EN.
//  Revision  : 1.0  initial release
// ============================================================================
module dsss_rx_descrambler_sync
  import dsss_rx_pkg::*;
#(
  parameter int          SYNC_MIN_ONES = 32,
  parameter logic [15:0] SFD_PATTERN   = SFD_LONG,
  parameter int          SFD_TIMEOUT   = 200
) (
  input  logic clk,
  input  logic rst,
`ifdef DESCR_BYPASS_EN
  input  logic bypass,
`endif
  input  logic in_valid,
  input  logic bit_in,
  input  logic frame_end,
  output logic bit_out,
  output logic out_valid,
  output logic locked,
  output logic sfd_det,
  output logic sync_lost
);

  localparam int ONES_W = $clog2(SYNC_MIN_ONES + 1);
  localparam int TMO_W  = $clog2(SFD_TIMEOUT + 1);
  localparam int WARM_W = $clog2(LFSR_LEN + 1);

  localparam logic [ONES_W-1:0] c_ones_tgt = ONES_W'(SYNC_MIN_ONES);
  localparam logic [TMO_W-1:0]  c_tmo_tgt  = TMO_W'(SFD_TIMEOUT);
  localparam logic [WARM_W-1:0] c_warm_tgt = WARM_W'(LFSR_LEN);

  rx_state_t          r_state, w_state_nxt;
  logic [ONES_W-1:0]  r_ones_cnt, w_ones_nxt, w_ones_inc;
  logic [TMO_W-1:0]   r_tmo_cnt, w_tmo_nxt, w_tmo_inc;
  logic [WARM_W-1:0]  r_warm_cnt, w_warm_nxt;
  logic [15:0]        r_win, w_win_nxt, w_win_shift;
  logic               r_bit_out, w_bit_out_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic               r_locked;
  logic               r_sfd_det, w_sfd_det_nxt;
  logic               r_sync_lost, w_sync_lost_nxt;
  logic               w_d;
  logic               w_warm_done;

  dsss_descrambler_core u_core (
    .clk    (clk),
    .rst    (rst),
    .en     (in_valid),
    .bit_in (bit_in),
    .d      (w_d)
  );

  assign w_warm_done = (r_warm_cnt == c_warm_tgt);
  assign w_ones_inc  = (r_ones_cnt == c_ones_tgt) ? r_ones_cnt : r_ones_cnt + ONES_W'(1);
  assign w_tmo_inc   = (r_tmo_cnt == c_tmo_tgt) ? r_tmo_cnt : r_tmo_cnt + TMO_W'(1);
  // Oldest bit lands in win[0], so an LSB-first SFD compares directly.
  assign w_win_shift = {w_d, r_win[15:1]};

  always_comb begin
    w_state_nxt     = r_state;
    w_ones_nxt      = r_ones_cnt;
    w_tmo_nxt       = r_tmo_cnt;
    w_warm_nxt      = r_warm_cnt;
    w_win_nxt       = r_win;
    w_bit_out_nxt   = 1'b0;
    w_out_valid_nxt = 1'b0;
    w_sfd_det_nxt   = 1'b0;
    w_sync_lost_nxt = 1'b0;

    if (in_valid && !w_warm_done) begin
      w_warm_nxt = r_warm_cnt + WARM_W'(1);
    end

    case (r_state)
      HUNT: begin
        if (in_valid && w_warm_done) begin
          if (!w_d) begin
            w_ones_nxt = '0;
          end else begin
            w_ones_nxt = w_ones_inc;
            if (w_ones_inc == c_ones_tgt) begin
              w_state_nxt = SFD_SEARCH;
              w_win_nxt   = '0;
              w_tmo_nxt   = '0;
            end
          end
        end
      end

      SFD_SEARCH: begin
        if (in_valid) begin
          w_win_nxt = w_win_shift;
          w_tmo_nxt = w_tmo_inc;
          if (w_win_shift == SFD_PATTERN) begin
            w_state_nxt   = DATA;
            w_sfd_det_nxt = 1'b1;
          end else if (w_tmo_inc == c_tmo_tgt) begin
            w_state_nxt     = HUNT;
            w_sync_lost_nxt = 1'b1;
            w_ones_nxt      = '0;
          end
        end
      end

      DATA: begin
        if (in_valid) begin
          w_out_valid_nxt = 1'b1;
          w_bit_out_nxt   = w_d;
        end
        // The history register is left alone so the next frame needs no warm-up.
        if (frame_end) begin
          w_state_nxt = HUNT;
          w_ones_nxt  = '0;
        end
      end

      default: begin
        w_state_nxt = HUNT;
        w_ones_nxt  = '0;
      end
    endcase

`ifdef DESCR_BYPASS_EN
    if (bypass) begin
      w_out_valid_nxt = in_valid;
      w_bit_out_nxt   = in_valid & bit_in;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= HUNT;
      r_ones_cnt  <= '0;
      r_tmo_cnt   <= '0;
      r_warm_cnt  <= '0;
      r_win       <= '0;
      r_bit_out   <= 1'b0;
      r_out_valid <= 1'b0;
      r_locked    <= 1'b0;
      r_sfd_det   <= 1'b0;
      r_sync_lost <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ones_cnt  <= w_ones_nxt;
      r_tmo_cnt   <= w_tmo_nxt;
      r_warm_cnt  <= w_warm_nxt;
      r_win       <= w_win_nxt;
      r_bit_out   <= w_bit_out_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_locked    <= (w_state_nxt != HUNT);
      r_sfd_det   <= w_sfd_det_nxt;
      r_sync_lost <= w_sync_lost_nxt;
    end
  end

  assign bit_out   = r_bit_out;
  assign out_valid = r_out_valid;
  assign locked    = r_locked;
  assign sfd_det   = r_sfd_det;
  assign sync_lost = r_sync_lost;

endmodule
`default_nettype wire

// File: tb/tb_dsss_rx_descrambler_sync.sv
`default_nettype none
// ============================================================================
//  Module    : tb_dsss_rx_descrambler_sync
//  Purpose   : Directed bench; stimulus from a model 802.11b TX scrambler.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_dsss_rx_descrambler_sync;

  logic clk = 1'b0;
  logic rst, in_valid, bit_in, frame_end;
  logic bit_out, out_valid, locked, sfd_det, sync_lost;
`ifdef DESCR_BYPASS_EN
  logic bypass;
`endif

  int checks = 0;
  int errors = 0;
  logic [6:0] tx_sr;

  always #5 clk = ~clk;

  dsss_rx_descrambler_sync dut (
    .clk       (clk),
    .rst       (rst),
`ifdef DESCR_BYPASS_EN
    .bypass    (bypass),
`endif
    .in_valid  (in_valid),
    .bit_in    (bit_in),
    .frame_end (frame_end),
    .bit_out   (bit_out),
    .out_valid (out_valid),
    .locked    (locked),
    .sfd_det   (sfd_det),
    .sync_lost (sync_lost)
  );

  // One clock of stimulus; scrambles unless raw. Outputs sampled 1ns after the edge.
  task automatic drive(input logic v, input logic data, input logic fe, input logic raw);
    logic s;
    @(negedge clk);
    s = 1'b0;
    if (v) begin
      if (raw) begin
        s = data;
      end else begin
        s = data ^ tx_sr[3] ^ tx_sr[6];
        tx_sr = {tx_sr[5:0], s};
      end
    end
    in_valid  = v;
    bit_in    = s;
    frame_end = fe;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; bit_in = 1'b0; frame_end = 1'b0;
    tx_sr = 7'b1101100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic send_sfd();
    logic [15:0] p;
    p = 16'hF3A0;
    for (int i = 0; i < 16; i++) drive(1'b1, p[i], 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; bit_in = 1'b0; frame_end = 1'b0;
`ifdef DESCR_BYPASS_EN
    bypass = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bit_out !== 1'b0)   begin errors++; $display("FAIL reset_bit_out: got %b expected 0", bit_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (locked !== 1'b0)    begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
    checks++; if (sfd_det !== 1'b0)   begin errors++; $display("FAIL reset_sfd_det: got %b expected 0", sfd_det); end
    checks++; if (sync_lost !== 1'b0) begin errors++; $display("FAIL reset_sync_lost: got %b expected 0", sync_lost); end
  endtask

  task automatic test_long_preamble();
    logic [7:0] b;
    do_reset();
    for (int i = 1; i <= 128; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      if (i == 38) begin
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_bit38: got %b expected 0", locked); end
      end
      if (i == 39) begin
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_bit39: got %b expected 1", locked); end
      end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL preamble_no_output: got %b expected 0", out_valid); end
    b = 8'hF3;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, (i < 8) ? b[i] : 1'b0, 1'b0, 1'b0);
      if (i == 7) b = 8'hF3;
    end
    checks++; if (sfd_det !== 1'b0) begin errors++; $display("FAIL wrong_sfd_no_det: got %b expected 0", sfd_det); end
    do_reset();
    send_ones(128);
    for (int i = 0; i < 16; i++) begin
      logic [15:0] p;
      p = 16'hF3A0;
      drive(1'b1, p[i], 1'b0, 1'b0);
      if (i == 14) begin
        checks++; if (sfd_det !== 1'b0) begin errors++; $display("FAIL sfd_early: got %b expected 0", sfd_det); end
      end
    end
    checks++; if (sfd_det !== 1'b1) begin errors++; $display("FAIL sfd_det_pulse: got %b expected 1", sfd_det); end
    b = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, b[i], 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL data_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (bit_out !== b[i])   begin errors++; $display("FAIL data_bit[%0d]: got %b expected %b", i, bit_out, b[i]); end
      if (i == 0) begin
        checks++; if (sfd_det !== 1'b0) begin errors++; $display("FAIL sfd_det_width: got %b expected 0", sfd_det); end
      end
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL frame_end_idle: locked=%b expected 0", locked); end
  endtask

  task automatic test_sfd_timeout();
    do_reset();
    send_ones(39);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL tmo_locked: got %b expected 1", locked); end
    for (int i = 1; i <= 200; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 199) begin
        checks++; if (sync_lost !== 1'b0) begin errors++; $display("FAIL tmo_early: sync_lost=%b expected 0", sync_lost); end
        checks++; if (locked !== 1'b1)    begin errors++; $display("FAIL tmo_early_lock: locked=%b expected 1", locked); end
      end
    end
    checks++; if (sync_lost !== 1'b1) begin errors++; $display("FAIL tmo_pulse: sync_lost=%b expected 1", sync_lost); end
    checks++; if (locked !== 1'b0)    begin errors++; $display("FAIL tmo_unlock: locked=%b expected 0", locked); end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (sync_lost !== 1'b0) begin errors++; $display("FAIL tmo_width: sync_lost=%b expected 0", sync_lost); end
    send_ones(31);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_early: locked=%b expected 0", locked); end
    send_ones(1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock: locked=%b expected 1", locked); end
  endtask

  task automatic test_gapped();
    logic [15:0] p;
    logic [7:0]  b;
    logic        v;
    do_reset();
    p = 16'hF3A0;
    b = 8'hA5;
    for (int i = 0; i < 152; i++) begin
      v = (i < 128) ? 1'b1 : (i < 144) ? p[i-128] : b[i-144];
      drive(1'b1, v, 1'b0, 1'b0);
      if (i == 38) begin
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL gap_lock: got %b expected 1", locked); end
      end
      if (i == 143) begin
        checks++; if (sfd_det !== 1'b1) begin errors++; $display("FAIL gap_sfd: got %b expected 1", sfd_det); end
      end
      if (i >= 144) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gap_valid[%0d]: got %b expected 1", i-144, out_valid); end
        checks++; if (bit_out !== v)      begin errors++; $display("FAIL gap_bit[%0d]: got %b expected %b", i-144, bit_out, v); end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_idle_valid[%0d]: got %b expected 0", i, out_valid); end
      if (i == 143) begin
        checks++; if (sfd_det !== 1'b0) begin errors++; $display("FAIL gap_sfd_idle: got %b expected 0", sfd_det); end
      end
    end
  endtask

  task automatic test_frame_end();
    logic [19:0] p;
    logic [7:0]  b;
    int          nout;
    do_reset();
    send_ones(128);
    send_sfd();
    p = 20'hB38E5;
    nout = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, p[i], (i == 19), 1'b0);
      if (out_valid === 1'b1) nout++;
      checks++; if (bit_out !== p[i]) begin errors++; $display("FAIL fe_bit[%0d]: got %b expected %b", i, bit_out, p[i]); end
    end
    checks++; if (nout != 20)      begin errors++; $display("FAIL fe_count: got %0d expected 20", nout); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL fe_unlock: got %b expected 0", locked); end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fe_after: out_valid=%b expected 0", out_valid); end
    send_ones(31);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL fe2_early: locked=%b expected 0", locked); end
    send_ones(1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL fe2_lock_nowarm: locked=%b expected 1", locked); end
    send_ones(20);
    send_sfd();
    checks++; if (sfd_det !== 1'b1) begin errors++; $display("FAIL fe2_sfd: got %b expected 1", sfd_det); end
    b = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, b[i], 1'b0, 1'b0);
      checks++; if (bit_out !== b[i] || out_valid !== 1'b1) begin
        errors++; $display("FAIL fe2_bit[%0d]: got %b/%b expected %b/1", i, bit_out, out_valid, b[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    send_ones(128);
    send_sfd();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || bit_out !== 1'b1 || locked !== 1'b1) begin
      errors++; $display("FAIL ar_pre: got ov=%b bit=%b lk=%b expected 1/1/1", out_valid, bit_out, locked);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid: got %b expected 0", out_valid); end
    checks++; if (locked !== 1'b0)    begin errors++; $display("FAIL ar_locked: got %b expected 0", locked); end
    checks++; if (bit_out !== 1'b0)   begin errors++; $display("FAIL ar_bit_out: got %b expected 0", bit_out); end
    @(negedge clk);
    rst = 1'b0;
    send_ones(38);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL ar_relock_early: locked=%b expected 0", locked); end
    send_ones(1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL ar_relock: locked=%b expected 1", locked); end
  endtask

`ifdef DESCR_BYPASS_EN
  task automatic test_bypass();
    logic [7:0] b;
    do_reset();
    bypass = 1'b1;
    b = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, b[i], 1'b0, 1'b1);
      checks++; if (bit_out !== b[i] || out_valid !== 1'b1) begin
        errors++; $display("FAIL byp_bit[%0d]: got %b/%b expected %b/1", i, bit_out, out_valid, b[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL byp_idle: got %b expected 0", out_valid); end
    bypass = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_long_preamble();
    test_sfd_timeout();
    test_gapped();
    test_frame_end();
    test_async_reset();
`ifdef DESCR_BYPASS_EN
    test_bypass();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
